// File: rtl/operand_loader.sv
// operand_loader: gathers three serial words into a stable operand set for the arithmetic stage
module operand_loader #(
  parameter int W     = 14,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [W-1:0]     i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ack,
  input  logic             i_flush,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_b,
  output logic [W-1:0]     o_c,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_sets
);
  typedef enum logic [1:0] {S_A, S_B, S_C, S_HOLD} state_t;
  state_t state, state_nxt;
  logic   ld_a, ld_b, ld_c, ack_set;
  assign o_ready = state != S_HOLD;
  // next state and load strobes; a flush forces S_A and suppresses every load and ack
  always_comb begin
    state_nxt = S_A;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_c      = 1'b0;
    ack_set   = 1'b0;
    if (!i_flush)
      case (state)
        S_A: begin
          ld_a      = i_valid;
          state_nxt = i_valid ? S_B : S_A;
        end
        S_B: begin
          ld_b      = i_valid;
          state_nxt = i_valid ? S_C : S_B;
        end
        S_C: begin
          ld_c      = i_valid;
          state_nxt = i_valid ? S_HOLD : S_C;
        end
        S_HOLD: begin
          ack_set   = i_ack;
          state_nxt = i_ack ? S_A : S_HOLD;
        end
        default: state_nxt = S_A;
      endcase
  end
  // state, operand and set-counter registers; o_valid mirrors the next state being S_HOLD
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_A;
      o_a     <= '0;
      o_b     <= '0;
      o_c     <= '0;
      o_valid <= 1'b0;
      o_sets  <= '0;
    end else begin
      state   <= state_nxt;
      o_valid <= state_nxt == S_HOLD;
      if (i_flush) begin
        o_a <= '0;
        o_b <= '0;
        o_c <= '0;
      end else begin
        if (ld_a) o_a <= i_data;
        if (ld_b) o_b <= i_data;
        if (ld_c) o_c <= i_data;
      end
      if (ack_set) o_sets <= o_sets + 1'b1;
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed stimulus with a queue-based reference model and literal spot checks
module tb_operand_loader;
  localparam int W = 14;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         i_valid = 1'b0, i_ack = 1'b0, i_flush = 1'b0;
  logic         o_ready, o_valid, o_ready2, o_valid2;
  logic [W-1:0] o_a, o_b, o_c, o_a2, o_b2, o_c2;
  logic [7:0]   o_sets;
  logic [1:0]   o_sets2;
  int vectors = 0, errs = 0;
  bit arm = 1'b0;

  operand_loader #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_ack(i_ack), .i_flush(i_flush), .o_a(o_a), .o_b(o_b), .o_c(o_c),
    .o_valid(o_valid), .o_sets(o_sets));

  operand_loader #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready2),
    .i_ack(i_ack), .i_flush(i_flush), .o_a(o_a2), .o_b(o_b2), .o_c(o_c2),
    .o_valid(o_valid2), .o_sets(o_sets2));

  always #5 clk = ~clk;

  // reference model: words collect in a queue until three are present, then form a held set
  logic [W-1:0] m_op [3];
  logic [W-1:0] m_q [$];
  bit           m_valid;
  int           m_sets;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_op[0] = '0; m_op[1] = '0; m_op[2] = '0;
      m_valid = 1'b0;
      m_sets  = 0;
    end else if (i_flush) begin
      m_q.delete();
      m_op[0] = '0; m_op[1] = '0; m_op[2] = '0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (i_ack) begin
        m_valid = 1'b0;
        m_sets  = m_sets + 1;
      end
    end else if (i_valid) begin
      m_op[m_q.size()] = i_data;
      m_q.push_back(i_data);
      if (m_q.size() == 3) begin
        m_valid = 1'b1;
        m_q.delete();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge, DUT outputs against the model
  always @(negedge clk) if (arm) begin
    check("model o_a", int'(o_a), int'(m_op[0]));
    check("model o_b", int'(o_b), int'(m_op[1]));
    check("model o_c", int'(o_c), int'(m_op[2]));
    check("model o_valid", int'(o_valid), int'(m_valid));
    check("model o_ready", int'(o_ready), int'(!m_valid));
    check("model o_sets", int'(o_sets), m_sets % 256);
    check("model o_sets2", int'(o_sets2), m_sets % 4);
    check("model o_a2", int'(o_a2), int'(m_op[0]));
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic a, input logic f);
    i_valid = v; i_data = d; i_ack = a; i_flush = f;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_ack = 1'b0; i_flush = 1'b0;
  endtask

  task automatic load3(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    drive(1, x, 0, 0);
    drive(1, y, 0, 0);
    drive(1, z, 0, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    arm = 1'b1;
    #2;
    check("reset o_ready", int'(o_ready), 1);
    check("reset o_valid", int'(o_valid), 0);
    check("reset o_a", int'(o_a), 0);
    check("reset o_sets", int'(o_sets), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load3(1, 4, 3);
    check("stream o_a", int'(o_a), 1);
    check("stream o_b", int'(o_b), 4);
    check("stream o_c", int'(o_c), 3);
    check("stream o_valid", int'(o_valid), 1);
    check("stream o_ready", int'(o_ready), 0);
    for (int i = 0; i < 5; i++) drive(1, 7, 0, 0);
    check("hold o_a", int'(o_a), 1);
    check("hold o_c", int'(o_c), 3);
    check("hold o_valid", int'(o_valid), 1);
    drive(0, 0, 1, 0);
    check("ack o_valid", int'(o_valid), 0);
    check("ack o_sets", int'(o_sets), 1);
    load3(4, 5, 9);
    check("second o_a", int'(o_a), 4);
    check("second o_b", int'(o_b), 5);
    check("second o_c", int'(o_c), 9);
    drive(0, 0, 1, 0);
    check("second ack o_sets", int'(o_sets), 2);
    drive(1, 2, 0, 0);
    drive(1, 6, 0, 0);
    drive(1, 8, 0, 1);
    check("flush o_a", int'(o_a), 0);
    check("flush o_b", int'(o_b), 0);
    check("flush o_valid", int'(o_valid), 0);
    check("flush o_ready", int'(o_ready), 1);
    check("flush o_sets", int'(o_sets), 2);
    drive(0, 0, 0, 0);
    load3(5, 14'h3FFF, 6);
    check("after flush o_a", int'(o_a), 5);
    check("wide o_b", int'(o_b), 16383);
    drive(0, 0, 1, 1);
    check("ack+flush o_valid", int'(o_valid), 0);
    check("ack+flush o_sets", int'(o_sets), 2);
    check("ack+flush o_a", int'(o_a), 0);
    drive(0, 0, 1, 0);
    check("ack ignored in S_A", int'(o_sets), 2);
    drive(1, 3, 0, 0);
    drive(0, 9, 1, 0);
    drive(0, 9, 0, 0);
    check("idle S_B o_a", int'(o_a), 3);
    check("idle S_B o_b", int'(o_b), 0);
    check("idle S_B o_ready", int'(o_ready), 1);
    drive(1, 1, 0, 0);
    drive(1, 2, 0, 0);
    drive(0, 0, 1, 0);
    check("third ack o_sets2", int'(o_sets2), 3);
    for (int k = 4; k <= 6; k++) begin
      load3(W'(k), W'(k + 1), W'(k + 2));
      drive(0, 0, 1, 0);
      check("wrap o_sets2", int'(o_sets2), k % 4);
      check("wrap o_sets", int'(o_sets), k);
    end
    drive(1, 20, 0, 0);
    drive(1, 21, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst o_a", int'(o_a), 0);
    check("async rst o_b", int'(o_b), 0);
    check("async rst o_sets", int'(o_sets), 0);
    check("async rst o_ready", int'(o_ready), 1);
    drive(1, 30, 0, 0);
    check("rst held o_a", int'(o_a), 0);
    rst_n = 1'b1;
    load3(10, 11, 12);
    check("post rst o_a", int'(o_a), 10);
    check("post rst o_b", int'(o_b), 11);
    check("post rst o_c", int'(o_c), 12);
    check("post rst o_valid", int'(o_valid), 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter W, default 14, operand and data width in bits.
REQ-002 Parameter CNT_W, default 8, width of the completed-set counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port i_data  input  W  serial operand word from upstream.
REQ-006 Port i_valid  input  1  i_data is valid this cycle.
REQ-007 Port o_ready  output  1  loader can accept a word this cycle.
REQ-008 Port i_ack  input  1  downstream has consumed the presented operand set.
REQ-009 Port i_flush  input  1  synchronous abort of the current set.
REQ-010 Port o_a  output  W  first operand of the set, feeding the arithmetic stage's i_a.
REQ-011 Port o_b  output  W  second operand, feeding i_b.
REQ-012 Port o_c  output  W  third operand, feeding i_c.
REQ-013 Port o_valid  output  1  o_a/o_b/o_c hold a complete, stable set.
REQ-014 Port o_sets  output  CNT_W  count of sets acknowledged by downstream.

Function
REQ-015 FSM states SHALL be S_A, S_B, S_C and S_HOLD, fully encoded; any unused encoding SHALL go to S_A on the next edge.
REQ-016 A word SHALL be accepted on a rising edge only when i_valid=1 and o_ready=1.
REQ-017 o_ready SHALL be 1 in S_A, S_B and S_C, and 0 in S_HOLD (a combinational decode of state only).
REQ-018 On acceptance in S_A: o_a<=i_data and go to S_B; in S_B: o_b<=i_data and go to S_C; in S_C: o_c<=i_data and go to S_HOLD.
REQ-019 With no accepted word, S_A, S_B and S_C SHALL hold their state and registers unchanged.
REQ-020 o_valid SHALL be registered: 1 exactly while in S_HOLD; it rises on the same edge that accepts the third word (latency 0 cycles after that edge).
REQ-021 o_a, o_b and o_c SHALL remain stable throughout S_HOLD regardless of i_valid or i_data.
REQ-022 In S_HOLD with i_ack=1: go to S_A, clear o_valid and increment o_sets by 1 on the same edge.
REQ-023 i_ack SHALL be ignored in S_A, S_B and S_C.
REQ-024 o_sets SHALL wrap from 2^CNT_W-1 to 0 without saturating or flagging.
REQ-025 i_flush=1 SHALL have priority over every other input: on that edge go to S_A, clear o_valid and clear o_a/o_b/o_c to 0; o_sets is unchanged; any word presented that cycle is dropped.
REQ-026 i_flush and i_ack both high in S_HOLD: flush wins and o_sets SHALL NOT increment.
REQ-027 No arithmetic SHALL be performed on the data path; words pass through unmodified at width W.

Reset
REQ-028 i_rst_n=0 SHALL immediately, without a clock edge, force: state S_A, o_a=o_b=o_c=0, o_valid=0, o_sets=0.
REQ-029 While i_rst_n=0, o_ready SHALL be 1 by decode of S_A; no word is accepted because state is held.
REQ-030 Reset asserted mid-set (in S_B or S_C) SHALL discard partial operands; the first accepted word after release is loaded into o_a.
REQ-031 Reset release SHALL be synchronous to clk in the surrounding logic; the block needs no internal synchronizer.

Verification
REQ-032 After reset, stream 1,4,3 with i_valid=1 on consecutive edges -> o_a=1, o_b=4, o_c=3, o_valid=1 after the third edge, o_ready=0.
REQ-033 Hold S_HOLD for 5 cycles with i_valid=1 and i_data=7 -> outputs unchanged; i_ack pulse -> o_valid=0, o_sets=1; then stream 4,5,9 -> o_a=4, o_b=5, o_c=9.
REQ-034 Stream 2,6 then i_flush=1 while i_valid=1 with i_data=8 -> state S_A, o_a=o_b=o_c=0, o_valid=0, word 8 dropped, o_sets unchanged.
REQ-035 In S_HOLD assert i_ack and i_flush together -> S_A, o_valid=0, o_sets not incremented.
REQ-036 With CNT_W=2, complete and acknowledge 5 sets -> o_sets sequence 1,2,3,0,1.
REQ-037 Pull i_rst_n low between clk edges while in S_C -> outputs zero immediately; after release, stream 10,11,12 -> o_a=10, o_b=11, o_c=12.
